// File: rtl/mux_sel_arbiter.sv
// Two-way round-robin arbiter that drives the select line of a 2:1 data mux.
// All outputs are registered so sel reaches the mux glitch-free.

module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_0,
  input  logic req_1,
  output logic sel,
  output logic grant_0,
  output logic grant_1,
  output logic busy,
  output logic switch_pulse
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] next_cnt;
  logic          last;
  logic          next_last;
  logic          next_sel;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_last  = last;
    next_sel   = sel;

    case (state)
      IDLE: begin
        if (req_0 && req_1)  next_state = last ? G0 : G1;
        else if (req_0)      next_state = G0;
        else if (req_1)      next_state = G1;
      end
      G0: begin
        if (!req_0 && req_1)                 next_state = G1;
        else if (!req_0)                     next_state = IDLE;
        else if (req_1 && (cnt == CNT_MAX))  next_state = G1;
        else if (cnt != CNT_MAX)             next_cnt   = cnt + CW'(1);
      end
      G1: begin
        if (!req_1 && req_0)                 next_state = G0;
        else if (!req_1)                     next_state = IDLE;
        else if (req_0 && (cnt == CNT_MAX))  next_state = G0;
        else if (cnt != CNT_MAX)             next_cnt   = cnt + CW'(1);
      end
      default: next_state = IDLE;
    endcase

    // Any entry into a grant state restarts the hold count and records the winner.
    if (next_state != state) begin
      if (next_state == G0) begin
        next_cnt  = '0;
        next_last = 1'b0;
      end else if (next_state == G1) begin
        next_cnt  = '0;
        next_last = 1'b1;
      end
    end

    if (next_state == G0)      next_sel = 1'b0;
    else if (next_state == G1) next_sel = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= 1'b1;
      sel          <= 1'b0;
      grant_0      <= 1'b0;
      grant_1      <= 1'b0;
      busy         <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= next_cnt;
      last         <= next_last;
      sel          <= next_sel;
      grant_0      <= (next_state == G0);
      grant_1      <= (next_state == G1);
      busy         <= (next_state != IDLE);
      switch_pulse <= (next_sel != sel);
    end
  end

endmodule

// Downstream 2:1 data mux steered by the arbiter's sel output.
module mux_using_case #(
  parameter int W = 8
) (
  input  logic [W-1:0] din_0,
  input  logic [W-1:0] din_1,
  input  logic         sel,
  output logic [W-1:0] mux_out
);

  always_comb begin
    case (sel)
      1'b0:    mux_out = din_0;
      default: mux_out = din_1;
    endcase
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that generates the select line for the downstream 2:1 data mux (mux_using_case).
- Two requesters compete for the mux output. The block grants one at a time, drives sel to match, and forces a hand-over after MAX_HOLD cycles when both are requesting.
- All outputs are registered, so sel is glitch-free at the mux input.

Parameters:
MAX_HOLD, 4, max consecutive grant cycles while the other side is requesting; legal range >= 2
CW, $clog2(MAX_HOLD), hold-counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
req_0  input  1  requester 0 wants din_0 routed to mux_out
req_1  input  1  requester 1 wants din_1 routed to mux_out
sel  output  1  to mux sel; 0 selects din_0, 1 selects din_1
grant_0  output  1  requester 0 currently owns the mux
grant_1  output  1  requester 1 currently owns the mux
busy  output  1  grant_0 | grant_1 (registered)
switch_pulse  output  1  one-cycle high in the first cycle sel takes a new value

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, rst_n. Nothing changes except on the clk rising edge.
- Reset values: state=IDLE, sel=0, grant_0=0, grant_1=0, busy=0, switch_pulse=0, hold counter cnt=0, internal last=1 (so requester 0 wins the first tie).
- Reset mid-operation: rst_n low at an edge clears everything above regardless of state or requests.
- States: IDLE, G0, G1. Outputs in each state:
  - IDLE: grants 0; sel holds its last value.
  - G0: grant_0=1, sel=0.
  - G1: grant_1=1, sel=1.
- Latency: a request seen at edge N gives grant/sel at edge N (visible after edge N), i.e. one cycle from request assertion to grant.
- IDLE transitions:
  - req_0 & req_1 -> grant the side opposite `last`.
  - only req_0 -> G0.
  - only req_1 -> G1.
  - none -> stay in IDLE.
- Entering G0 or G1 loads cnt=0 and sets last to that side.
- In Gx, evaluated each edge (x = owner, y = other side):
  - !req_x & req_y -> Gy (direct hand-over, no IDLE bubble).
  - !req_x & !req_y -> IDLE.
  - req_x & req_y & cnt==MAX_HOLD-1 -> Gy (forced rotation).
  - otherwise -> stay, cnt = min(cnt+1, MAX_HOLD-1). cnt saturates; it does not wrap.
- Under continuous contention, each side holds for exactly MAX_HOLD cycles, then alternates.
- A sole requester keeps its grant indefinitely. Its cnt sits saturated, so when the other side raises a request the switch happens on the next edge.
- switch_pulse:
  - Registered; equals 1 in the cycle where sel differs from its previous-cycle value.
  - IDLE->G0 with sel already 0 produces no pulse.
- Invariant: grant_0 & grant_1 is never 1. busy == grant_0 | grant_1 every cycle.
- Requests are level-sensitive and not latched. A request pulse shorter than one cycle between edges is ignored.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 edges with req_0=req_1=1, then release -> during reset all outputs 0. First edge after release gives grant_0=1, sel=0, switch_pulse=0.
- Single requester: req_1=1 from idle with sel=0 -> next edge grant_1=1, sel=1, switch_pulse=1 for exactly 1 cycle. Hold req_1 for 20 cycles -> grant_1 stays 1 and sel stays 1 throughout.
- Contention rotation, MAX_HOLD=4: req_0=req_1=1 held for 16 cycles -> sel sequence 0000 1111 0000 1111 from the first grant edge. switch_pulse fires on cycles 5, 9 and 13.
- Early release: in G0 with both requesting and cnt=1, drop req_0 -> next edge grant_1=1, sel=1, with no IDLE cycle in between.
- Return to idle: in G1, drop req_1 with req_0=0 -> next edge busy=0, grant_1=0, sel stays 1. Then req_0=1 -> G0, sel=0, switch_pulse=1.
- Reset mid-grant: in G1 with cnt=2, pulse rst_n low for 1 edge -> sel=0 and grants 0. After release with both requesting, G0 is granted (last reset to 1).
- All scenarios: check the mutual-exclusion and busy invariants every cycle. Also drive din_0 and din_1 into mux_using_case and confirm mux_out tracks the granted input.
